// File: rtl/fetch_redirect_pkg.sv
// Shared definitions for the fetch/redirect path: opcode constants, reset PC
// default and the branch-target alignment helper.
package fetch_redirect_pkg;

  localparam int          INSTR_W      = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0100_0000;
  localparam logic [31:0] PC_STEP      = 32'd4;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // JALR computes rs1+imm, so bit0 must be cleared before it becomes a PC
  function automatic logic [INSTR_W-1:0] align_tgt(input logic [INSTR_W-1:0] raw);
    return {raw[INSTR_W-1:1], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_redirect_if.sv
// Bus between the execute/hazard logic and the fetch-redirect block.
interface fetch_redirect_if #(
  parameter int CNT_W = 16
);
  import fetch_redirect_pkg::*;

  logic               stall;
  logic               e_valid;
  logic               e_br_taken;
  logic               e_is_jump;
  logic [INSTR_W-1:0] e_target;
  logic [INSTR_W-1:0] f_pc;
  logic [INSTR_W-1:0] d_pc;
  logic               d_valid;
  logic               flush_e;
  logic               redirect;
  logic               misalign_err;
  logic [CNT_W-1:0]   redirect_cnt;

  modport slave (
    input  stall, e_valid, e_br_taken, e_is_jump, e_target,
    output f_pc, d_pc, d_valid, flush_e, redirect, misalign_err, redirect_cnt
  );

  modport master (
    output stall, e_valid, e_br_taken, e_is_jump, e_target,
    input  f_pc, d_pc, d_valid, flush_e, redirect, misalign_err, redirect_cnt
  );

endinterface

// File: rtl/fetch_redirect_fd_pipe_reg.sv
// PC + valid pipeline register with flush and hold controls; usable for F/D or D/E.
module fd_pipe_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         hold_i,
  input  logic         flush_i,
  input  logic [W-1:0] pc_i,
  output logic [W-1:0] pc_o,
  output logic         valid_o
);

  logic [W-1:0] pc_q,    pc_d;
  logic         valid_q, valid_d;

  // Flush outranks hold: a squashed slot must not keep stale state around
  always_comb begin
    pc_d    = pc_i;
    valid_d = 1'b1;
    if (flush_i) begin
      pc_d    = pc_q;
      valid_d = 1'b0;
    end else if (hold_i) begin
      pc_d    = pc_q;
      valid_d = valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign pc_o    = pc_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_redirect.sv
// Fetch PC owner: sequential advance, execute-stage redirect with squash,
// F/D register, sticky misaligned-target flag and saturating redirect counter.
module fetch_redirect
  import fetch_redirect_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          CNT_W    = 16
) (
  input logic              clock,
  input logic              reset,
  fetch_redirect_if.slave  bus
);

  logic               redirect;
  logic [INSTR_W-1:0] tgt;
  logic [INSTR_W-1:0] pc_q, pc_d;
  logic               mis_q, mis_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign redirect = bus.e_valid & (bus.e_br_taken | bus.e_is_jump);
  assign tgt      = align_tgt(bus.e_target);

  // Redirect beats stall: the stall comes from decode, which is being squashed
  always_comb begin
    pc_d = pc_q + PC_STEP;
    if (redirect)       pc_d = tgt;
    else if (bus.stall) pc_d = pc_q;
  end

  always_comb begin
    mis_d = mis_q;
    cnt_d = cnt_q;
    if (redirect) begin
      mis_d = mis_q | tgt[1];
      cnt_d = sat_inc(cnt_q);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q  <= RESET_PC;
      mis_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      pc_q  <= pc_d;
      mis_q <= mis_d;
      cnt_q <= cnt_d;
    end
  end

  fd_pipe_reg #(.W(INSTR_W)) u_fd (
    .clk     (clock),
    .rst     (reset),
    .hold_i  (bus.stall),
    .flush_i (redirect),
    .pc_i    (pc_q),
    .pc_o    (bus.d_pc),
    .valid_o (bus.d_valid)
  );

  assign bus.f_pc         = pc_q;
  assign bus.redirect     = redirect;
  assign bus.flush_e      = redirect;
  assign bus.misalign_err = mis_q;
  assign bus.redirect_cnt = cnt_q;

endmodule

// File: doc/fetch_redirect.md
Name: fetch_redirect

Overview:
- Fetch-side PC owner for the pd pipeline.
- Holds the fetch PC and advances it by 4 each cycle.
- Consumes the execute-stage branch decision (e_br_taken) and jump indications, redirects the PC to the execute-computed target, and squashes wrong-path instructions.
- Also holds the F/D pipeline register (PC + valid) and keeps a sticky misaligned-target flag and a redirect counter for debug.

Parameters:
- RESET_PC, 32'h0100_0000, PC value loaded on reset.
- CNT_W, 16, width of the redirect statistics counter.

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- stall  in  1  hazard-unit stall; holds F and F/D register
- e_valid  in  1  instruction in execute is valid (not a bubble)
- e_br_taken  in  1  branch comparator result; already 0 for non-branches
- e_is_jump  in  1  execute instruction is JAL or JALR
- e_target  in  32  execute-computed target (branch/JAL: pc+imm; JALR: rs1+imm, bit0 not yet cleared)
- f_pc  out  32  current fetch PC to instruction memory
- d_pc  out  32  PC of instruction in decode
- d_valid  out  1  decode slot holds a valid instruction
- flush_e  out  1  combinational; D/E register must load a bubble this edge
- redirect  out  1  combinational; a redirect is being taken this cycle
- misalign_err  out  1  sticky; a redirect target had bit1 set
- redirect_cnt  out  CNT_W  number of redirects since reset

Behaviour:
- redirect = e_valid & (e_br_taken | e_is_jump). flush_e = redirect.
- Effective target tgt = {e_target[31:1],1'b0}; bit0 is always cleared (covers JALR).
- f_pc next-state priority:
  - reset -> RESET_PC
  - redirect -> tgt
  - stall -> hold
  - otherwise -> f_pc+4, wrapping modulo 2^32 (32'hFFFF_FFFC+4 = 0).
- F/D register priority:
  - reset -> d_valid=0, d_pc=0
  - redirect -> d_valid=0, d_pc unchanged
  - stall -> hold
  - otherwise -> d_pc<=f_pc, d_valid<=1
- Redirect beats stall: the stall originates in decode, and decode is being squashed. Same edge: PC=tgt, d_valid=0.
- Redirect penalty: 2 bubbles (D and E squashed). The target instruction reaches decode 1 cycle after the redirect edge.
- misalign_err: set on a redirect when tgt[1]=1; cleared only by reset. The redirect is still taken.
- redirect_cnt: +1 per redirect cycle; saturates at all-ones, does not wrap; 0 on reset.
- e_br_taken or e_is_jump with e_valid=0: ignored entirely; no redirect, no count.
- Reset values: f_pc=RESET_PC, d_pc=0, d_valid=0, misalign_err=0, redirect_cnt=0. Combinational flush_e and redirect follow their inputs even during reset.
- Reset mid-redirect: reset wins; the PC loads RESET_PC.
- The first valid decode appears on the 2nd edge after reset deasserts (PC RESET_PC -> decode).

Decomposition:
- Shared package/header:
  - opcode constants (OP_BRANCH 7'b1100011, OP_JAL 7'b1101111, OP_JALR 7'b1100111)
  - RESET_PC default
  - instruction width 32
- Sub-module: fd_pipe_reg (PC + valid register with hold/flush controls). Reusable for the D/E register.
- e_is_jump is derived in the execute stage from the shared opcode constants, not inside this block.

Test Plan:
1. Reset, then 4 idle cycles.
   -> f_pc = 0x01000000, 0x01000004, 0x01000008, 0x0100000C.
   -> d_valid=1 from the 2nd post-reset edge with d_pc=0x01000000.
2. At f_pc=0x01000010, drive e_valid=1, e_br_taken=1, e_target=0x01000040.
   -> redirect=flush_e=1 that cycle.
   -> next cycle f_pc=0x01000040, d_valid=0.
   -> following cycle d_pc=0x01000040, d_valid=1; redirect_cnt=1.
3. stall=1 for 3 cycles at f_pc=0x01000020.
   -> f_pc and d_pc held, d_valid held.
   -> stall=1 together with e_is_jump=1, e_target=0x01000105: f_pc=0x01000104, d_valid=0, misalign_err=0.
4. JALR with e_target=0x01000202.
   -> f_pc=0x01000202, misalign_err=1 and stays 1 until reset.
5. e_valid=0 with e_br_taken=1, e_target=0x0.
   -> no redirect, f_pc increments by 4, redirect_cnt unchanged.
6. CNT_W=2, 5 consecutive redirects.
   -> redirect_cnt = 1,2,3,3,3.
   -> separately, with f_pc forced to 0xFFFFFFFC via redirect, next f_pc=0x00000000.
